// File: rtl/hamming_pkg.sv
// Shared (7,4) Hamming definitions: widths, generator rows,
// transmit FSM states and the nibble-to-codeword function.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    // Generator rows as codeword values, bit c0 in the LSB.
    localparam logic [CW_W-1:0] G_ROW0 = 7'h71;
    localparam logic [CW_W-1:0] G_ROW1 = 7'h52;
    localparam logic [CW_W-1:0] G_ROW2 = 7'h34;
    localparam logic [CW_W-1:0] G_ROW3 = 7'h68;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SEND_LO = 2'd1;
    localparam state_t ST_SEND_HI = 2'd2;

    function automatic logic [CW_W-1:0] hamming_enc(
        input logic [DATA_W-1:0] d
    );
        logic [CW_W-1:0] c;
        c[3:0] = d;
        c[4]   = d[0] ^ d[1] ^ d[2];
        c[5]   = d[0] ^ d[2] ^ d[3];
        c[6]   = d[0] ^ d[1] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_encode.sv
// Combinational (7,4) Hamming encoder: one nibble to one
// systematic codeword.
module hamming_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    output logic [CW_W-1:0]   cw_o
);

    assign cw_o = hamming_enc(d_i);

endmodule

// File: rtl/hamming_encode_tx.sv
// Byte-in, bit-out (7,4) Hamming transmitter with a one-byte
// pending buffer so back-to-back bytes leave no bubble.
module hamming_encode_tx
    import hamming_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       bit_o,
    output logic       bit_valid_o,
    input  logic       bit_ready_i,
    output logic       busy_o
);

    state_t          state_q, state_d;
    logic [CW_W-1:0] sh_q, sh_d;
    logic [CW_W-1:0] hold_q, hold_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      pend_q, pend_d;
    logic            pend_v_q, pend_v_d;

    logic [7:0]      src;
    logic [CW_W-1:0] cw_lo;
    logic [CW_W-1:0] cw_hi;
    logic [CW_W-1:0] sh_next;
    logic            byte_hs;
    logic            bit_hs;
    logic            last_bit;

    // A queued byte always takes precedence over a new offer.
    assign src = pend_v_q ? pend_q : byte_i;

    hamming_encode u_enc_lo (
        .d_i  (src[3:0]),
        .cw_o (cw_lo)
    );

    hamming_encode u_enc_hi (
        .d_i  (src[7:4]),
        .cw_o (cw_hi)
    );

    assign byte_ready_o = !pend_v_q;
    assign bit_valid_o  = (state_q != ST_IDLE);
    assign busy_o       = bit_valid_o || pend_v_q;
    assign byte_hs      = byte_valid_i && byte_ready_o;
    assign bit_hs       = bit_valid_o && bit_ready_i;
    assign last_bit     = bit_hs && (cnt_q == 3'd6);

    always_comb begin
        bit_o   = 1'b0;
        sh_next = sh_q;
        if (bit_valid_o) begin
            bit_o = LSB_FIRST ? sh_q[0] : sh_q[CW_W-1];
        end
        if (LSB_FIRST) begin
            sh_next = {1'b0, sh_q[CW_W-1:1]};
        end else begin
            sh_next = {sh_q[CW_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_hs) begin
                    sh_d    = cw_lo;
                    hold_d  = cw_hi;
                    cnt_d   = 3'd0;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (byte_hs) begin
                    pend_d   = byte_i;
                    pend_v_d = 1'b1;
                end
                if (last_bit) begin
                    sh_d    = hold_q;
                    cnt_d   = 3'd0;
                    state_d = ST_SEND_HI;
                end else if (bit_hs) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SEND_HI: begin
                if (last_bit) begin
                    // Pending drains first; otherwise a same-cycle
                    // offer bypasses the pending register.
                    if (pend_v_q || byte_hs) begin
                        sh_d     = cw_lo;
                        hold_d   = cw_hi;
                        cnt_d    = 3'd0;
                        pend_v_d = 1'b0;
                        state_d  = ST_SEND_LO;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (byte_hs) begin
                        pend_d   = byte_i;
                        pend_v_d = 1'b1;
                    end
                    if (bit_hs) begin
                        sh_d  = sh_next;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            hold_q   <= '0;
            cnt_q    <= 3'd0;
            pend_q   <= 8'h00;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: tb/tb_hamming_encode_tx.sv
// Self-checking bench for hamming_encode_tx: queue model of the
// code-bit stream plus directed literal sequences.
module tb_hamming_encode_tx;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic       bit_o;
    logic       bit_valid_o;
    logic       busy_o;
    logic       rdy_m;
    logic       bit_m;
    logic       bv_m;
    logic       busy_m;
    logic       rdy_fix;
    logic       rnd_en;
    logic       rnd_bit;
    logic       bit_ready;
    logic [3:0] nib;
    logic [6:0] enc_cw;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nready_seen = 0;
    int nbytes = 0;

    bit   qL[$];
    bit   qM[$];
    logic [7:0] qB[$];
    bit   logL[$];
    bit   logM[$];
    int   logC[$];

    logic [13:0] rxl, rxm;
    int   rxn = 0;
    bit   prev_stall = 0;
    bit   prev_bit = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom);
    assign bit_ready = rnd_en ? rnd_bit : rdy_fix;

    hamming_encode_tx #(.LSB_FIRST(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .bit_o        (bit_o),
        .bit_valid_o  (bit_valid_o),
        .bit_ready_i  (bit_ready),
        .busy_o       (busy_o)
    );

    hamming_encode_tx #(.LSB_FIRST(1'b0)) dut_msb (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (rdy_m),
        .bit_o        (bit_m),
        .bit_valid_o  (bv_m),
        .bit_ready_i  (bit_ready),
        .busy_o       (busy_m)
    );

    hamming_encode u_enc (
        .d_i  (nib),
        .cw_o (enc_cw)
    );

    // Codeword as the XOR of generator rows selected by data bits.
    function automatic logic [6:0] menc(input logic [3:0] d);
        logic [6:0] r;
        r = 7'h00;
        if (d[0]) r = r ^ 7'b1110001;
        if (d[1]) r = r ^ 7'b1010010;
        if (d[2]) r = r ^ 7'b0110100;
        if (d[3]) r = r ^ 7'b1101000;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [6:0] lo, hi;
        lo = menc(b[3:0]);
        hi = menc(b[7:4]);
        for (int i = 0; i < 7; i++) begin
            qL.push_back(lo[i]);
            qM.push_back(lo[6-i]);
        end
        for (int i = 0; i < 7; i++) begin
            qL.push_back(hi[i]);
            qM.push_back(hi[6-i]);
        end
        qB.push_back(b);
    endtask

    task automatic rx_word();
        logic [6:0] cl, ch, ml, mh;
        cl = rxl[6:0];
        ch = rxl[13:7];
        for (int i = 0; i < 7; i++) begin
            ml[6-i] = rxm[i];
            mh[6-i] = rxm[7+i];
        end
        chk("rx_syn_lo", {25'd0, menc(cl[3:0])}, {25'd0, cl});
        chk("rx_syn_hi", {25'd0, menc(ch[3:0])}, {25'd0, ch});
        chk("rx_syn_msb", {18'd0, menc(ml[3:0]), menc(mh[3:0])},
            {18'd0, ml, mh});
        if (qB.size() > 0) begin
            chk("rx_byte", {24'd0, ch[3:0], cl[3:0]}, {24'd0, qB[0]});
            chk("rx_byte_msb", {24'd0, mh[3:0], ml[3:0]}, {24'd0, qB[0]});
            void'(qB.pop_front());
        end else begin
            chk("rx_unexpected", 1, 0);
        end
        nbytes++;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_i) begin
            qL.delete();
            qM.delete();
            qB.delete();
            rxn = 0;
            prev_stall = 0;
        end else begin
            chk("bit_valid", {31'd0, bit_valid_o}, {31'd0, qL.size() > 0});
            chk("bit_valid_msb", {31'd0, bv_m}, {31'd0, qL.size() > 0});
            chk("busy", {31'd0, busy_o}, {31'd0, qL.size() > 0});
            chk("byte_ready", {31'd0, byte_ready_o},
                {31'd0, qL.size() <= 14});
            chk("byte_ready_msb", {31'd0, rdy_m}, {31'd0, qL.size() <= 14});
            if (qL.size() > 0) begin
                chk("bit_lsb", {31'd0, bit_o}, {31'd0, qL[0]});
                chk("bit_msb", {31'd0, bit_m}, {31'd0, qM[0]});
            end else begin
                chk("bit_idle", {30'd0, bit_o, bit_m}, 32'd0);
            end
            if (prev_stall)
                chk("stall_stable", {30'd0, bit_valid_o, bit_o},
                    {30'd0, 1'b1, prev_bit});
            if (!byte_ready_o) nready_seen++;
            if (bit_valid_o && bit_ready && qL.size() > 0) begin
                logL.push_back(bit_o);
                logM.push_back(bit_m);
                logC.push_back(cyc);
                rxl[rxn] = bit_o;
                rxm[rxn] = bit_m;
                rxn++;
                void'(qL.pop_front());
                void'(qM.pop_front());
                if (rxn == 14) begin
                    rx_word();
                    rxn = 0;
                end
            end
            if (byte_valid_i && byte_ready_o) push_byte(byte_i);
            prev_stall = bit_valid_o && !bit_ready;
            prev_bit = bit_o;
        end
    end

    // Called and returns at posedge + #1.
    task automatic put(input logic [7:0] b);
        bit ok;
        ok = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                ok = 1;
                break;
            end
        end
        chk("put_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            #1;
            if (!busy_o && !bit_valid_o) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        logL.delete();
        logM.delete();
        logC.delete();
    endtask

    int e21[14] = '{1,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int m01[7]  = '{1,1,1,0,0,0,1};
    logic [6:0] lit_cw[6] = '{7'h71, 7'h52, 7'h34, 7'h68, 7'h7F, 7'h00};
    logic [3:0] lit_d[6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0};

    initial begin
        int nb0;
        bit ok;
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        rdy_fix = 1'b1;
        rnd_en = 1'b0;
        nib = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_bit", {31'd0, bit_o}, 32'd0);
        chk("rst_valid", {31'd0, bit_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready_o}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            #1;
            chk("enc_model", {25'd0, enc_cw}, {25'd0, menc(4'(i))});
        end
        for (int i = 0; i < 6; i++) begin
            nib = lit_d[i];
            #1;
            chk("enc_lit", {25'd0, enc_cw}, {25'd0, lit_cw[i]});
            chk("model_lit", {25'd0, menc(lit_d[i])}, {25'd0, lit_cw[i]});
        end
        @(posedge clk);
        #1;

        clear_logs();
        put(8'h21);
        wait_idle();
        chk("b21_len", logL.size(), 14);
        if (logL.size() == 14) begin
            for (int i = 0; i < 14; i++)
                chk("b21_bit", {31'd0, logL[i]}, e21[i]);
            chk("b21_span", logC[13] - logC[0], 13);
        end
        chk("b21_end", {30'd0, bit_valid_o, busy_o}, 32'd0);

        clear_logs();
        put(8'h01);
        wait_idle();
        if (logM.size() >= 7) begin
            for (int i = 0; i < 7; i++)
                chk("msb01_bit", {31'd0, logM[i]}, m01[i]);
        end else begin
            chk("msb01_len", logM.size(), 14);
        end

        clear_logs();
        nready_seen = 0;
        put(8'h21);
        put(8'hF0);
        wait_idle();
        chk("b2b_len", logL.size(), 28);
        if (logL.size() == 28) begin
            chk("b2b_span", logC[27] - logC[0], 27);
            chk("b2b_hi0", {31'd0, logL[14]}, 32'd0);
            chk("b2b_f0_c4", {31'd0, logL[25]}, 32'd1);
        end
        chk("b2b_ready_low", {31'd0, nready_seen > 0}, 32'd1);

        clear_logs();
        put(8'h11);
        put(8'h22);
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (logL.size() >= 12) begin
                ok = 1;
                break;
            end
        end
        chk("rst_wait", {31'd0, ok}, 32'd1);
        chk("rst_pending", {31'd0, byte_ready_o}, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, bit_valid_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, byte_ready_o}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk);
        #1;
        nb0 = nbytes;
        put(8'h5A);
        wait_idle();
        chk("post_rst_bytes", nbytes - nb0, 1);

        nb0 = nbytes;
        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            put(8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        wait_idle();
        rnd_en = 1'b0;
        chk("rand_bytes", nbytes - nb0, 200);
        chk("rand_drained", qB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
